// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide unit with private HI/LO registers
// Shift-add multiply and restoring divide on magnitudes, one bit per RUN cycle, sign fix-up in FIN.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [1:0]  op_q, op_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d, dbz_q, dbz_d;

  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] prod_res;
  logic [31:0] quo_res, rem_res;

  assign a_neg = op[0] & A[31];
  assign b_neg = op[0] & B[31];
  assign mag_a = a_neg ? (~A + 32'd1) : A;
  assign mag_b = b_neg ? (~B + 32'd1) : B;

  // acc holds {partial product, remaining multiplier} for multiply, {unused, dividend/quotient} for divide
  assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
  assign div_shift = {rem_q, acc_q[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

  assign prod_res = (sign_a_q ^ sign_b_q) ? (~acc_q + 64'd1) : acc_q;
  assign quo_res  = (sign_a_q ^ sign_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_res  = sign_a_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          op_d     = op;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          opnd_d   = op[1] ? mag_b : mag_a;
          acc_d    = {32'd0, (op[1] ? mag_a : mag_b)};
          rem_d    = 32'd0;
          count_d  = 5'd0;
          dbz_d    = 1'b0;
        end else begin
          if (hi_we) hi_d = A;
          if (lo_we) lo_d = A;
        end
      end
      S_RUN: begin
        count_d = count_q + 5'd1;
        if (op_q[1]) begin
          rem_d = div_diff[33] ? div_shift[31:0] : div_diff[31:0];
          acc_d = {acc_q[63:32], acc_q[30:0], ~div_diff[33]};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        if (count_q == 5'd31) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (op_q[1]) begin
          if (opnd_q == 32'd0) begin
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_res;
            lo_d = quo_res;
          end
        end else begin
          hi_d = prod_res[63:32];
          lo_d = prod_res[31:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= 5'd0;
      op_q     <= 2'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      rem_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
// Each step drives inputs at negedge and samples outputs 1ns after the rising edge.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        hi_we, lo_we;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  int lat;
  logic dbz_acc;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op; lat = edges from the accept edge until done is seen (33 expected)
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int n, output logic dbz0);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
    dbz0 = div_by_zero;
    chk({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 32'd33);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; A = 32'd0; B = 32'd0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("multu", 2'b00, 32'h00008421, 32'h00001248, lat, dbz_acc);
    chk("multu_hi", hi, 32'h00000000);
    chk("multu_lo", lo, 32'h096F7B48);

    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd5, lat, dbz_acc);
    chk("mult_neg_hi", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo", lo, 32'hFFFFFFF1);

    run_op("mult_min", 2'b01, 32'h80000000, 32'h80000000, lat, dbz_acc);
    chk("mult_min_hi", hi, 32'h40000000);
    chk("mult_min_lo", lo, 32'h00000000);

    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, lat, dbz_acc);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);

    run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, lat, dbz_acc);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h00000000);

    @(negedge clk); hi_we = 1'b1; A = 32'h1111;
    @(posedge clk); #1; hi_we = 1'b0;
    chk("mthi", hi, 32'h00001111);
    @(negedge clk); lo_we = 1'b1; A = 32'h2222;
    @(posedge clk); #1; lo_we = 1'b0;
    chk("mtlo", lo, 32'h00002222);

    run_op("divu_zero", 2'b10, 32'd100, 32'd0, lat, dbz_acc);
    chk("divu_zero_hi", hi, 32'h00001111);
    chk("divu_zero_lo", lo, 32'h00002222);
    chk("divu_zero_flag", {31'd0, div_by_zero}, 32'd1);

    run_op("divu", 2'b10, 32'd100, 32'd7, lat, dbz_acc);
    chk("divu_dbz_cleared_at_accept", {31'd0, dbz_acc}, 32'd0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_dbz", {31'd0, div_by_zero}, 32'd0);

    // start and MTHI while busy must both be ignored
    @(negedge clk); start = 1'b1; op = 2'b00; A = 32'd3; B = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); start = 1'b1; op = 2'b10; A = 32'h0000DEAD; B = 32'd1; hi_we = 1'b1;
    @(posedge clk); #1; start = 1'b0; hi_we = 1'b0;
    chk("busy_mthi_ignored", hi, 32'd2);
    lat = 6;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_latency", lat, 32'd33);
    chk("busy_hi", hi, 32'd0);
    chk("busy_lo", lo, 32'd12);
    @(posedge clk); #1;
    chk("busy_no_queue", {31'd0, busy}, 32'd0);

    run_op("divu_zero2", 2'b10, 32'd5, 32'd0, lat, dbz_acc);
    chk("divu_zero2_flag", {31'd0, div_by_zero}, 32'd1);

    // asynchronous reset in the middle of RUN
    @(negedge clk); start = 1'b1; op = 2'b00; A = 32'd7; B = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #3; rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("post_rst", 2'b00, 32'd7, 32'd9, lat, dbz_acc);
    chk("post_rst_lo", lo, 32'd63);
    chk("post_rst_hi", hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
